// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-master data-memory port arbiter.
package pkg_mem_arb;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_e;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module arb_sat_counter #(
  parameter int unsigned CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inc,
  input  logic                clr,
  output logic [CntWidth-1:0] count_o
);

  logic [CntWidth-1:0] count_q;
  logic [CntWidth-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CntWidth{1'b1}})) begin
      count_d = count_q + {{(CntWidth-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between M0 and M1, one transaction in flight.
// Optional performance counters are compiled in with MEM_ARB_PERF_EN.
//
// Handshake: a master raises mX_req_i with write/addr/wdata and holds them stable until
// mX_ready_o pulses (1 cycle); it may drop or re-request on the following edge. The same
// req/ready contract applies downstream on mem_req_o / mem_ready_i.
module mem_port_arbiter
  import pkg_mem_arb::*;
#(
  parameter int unsigned DWidth   = 32,
  parameter int unsigned CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                m0_req_i,
  input  logic                m1_req_i,
  input  logic                m0_write_i,
  input  logic                m1_write_i,
  input  logic [DWidth-1:0]   m0_addr_i,
  input  logic [DWidth-1:0]   m1_addr_i,
  input  logic [DWidth-1:0]   m0_wdata_i,
  input  logic [DWidth-1:0]   m1_wdata_i,
  output logic                m0_ready_o,
  output logic                m1_ready_o,
  output logic [DWidth-1:0]   m0_rdata_o,
  output logic [DWidth-1:0]   m1_rdata_o,
  output logic                mem_req_o,
  output logic                mem_write_o,
  output logic [DWidth-1:0]   mem_addr_o,
  output logic [DWidth-1:0]   mem_wdata_o,
  input  logic                mem_ready_i,
  input  logic [DWidth-1:0]   mem_rdata_i,
  input  logic                perf_clr_i,
  output logic [CntWidth-1:0] perf_grant0_o,
  output logic [CntWidth-1:0] perf_grant1_o,
  output logic [CntWidth-1:0] perf_stall_o,
  output arb_state_e          state_o
);

  arb_state_e        state_q, state_d;
  master_id_e        last_q, last_d;
  logic              req_q, req_d;
  logic              write_q, write_d;
  logic [DWidth-1:0] addr_q, addr_d;
  logic [DWidth-1:0] wdata_q, wdata_d;
  logic              grant0, grant1;
  logic              stall;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    req_d   = req_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the master that did not win last time goes first.
        grant0 = m0_req_i && (!m1_req_i || (last_q == M1));
        grant1 = m1_req_i && (!m0_req_i || (last_q == M0));
        if (grant0) begin
          state_d = BUSY0;
          last_d  = M0;
          req_d   = 1'b1;
          write_d = m0_write_i;
          addr_d  = m0_addr_i;
          wdata_d = m0_wdata_i;
        end else if (grant1) begin
          state_d = BUSY1;
          last_d  = M1;
          req_d   = 1'b1;
          write_d = m1_write_i;
          addr_d  = m1_addr_i;
          wdata_d = m1_wdata_i;
        end
      end
      BUSY0, BUSY1: begin
        if (mem_ready_i) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= M1;
      req_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      req_q   <= req_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_write_o = write_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign state_o     = state_q;

  // Completion is returned combinationally, only to the master currently in service.
  assign m0_ready_o = (state_q == BUSY0) && mem_ready_i;
  assign m1_ready_o = (state_q == BUSY1) && mem_ready_i;
  assign m0_rdata_o = m0_ready_o ? mem_rdata_i : '0;
  assign m1_rdata_o = m1_ready_o ? mem_rdata_i : '0;

  assign stall = (m0_req_i && (state_q != BUSY0)) || (m1_req_i && (state_q != BUSY1));

`ifdef MEM_ARB_PERF_EN
  arb_sat_counter #(.CntWidth(CntWidth)) u_grant0_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc     (grant0),
    .clr     (perf_clr_i),
    .count_o (perf_grant0_o)
  );

  arb_sat_counter #(.CntWidth(CntWidth)) u_grant1_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc     (grant1),
    .clr     (perf_clr_i),
    .count_o (perf_grant1_o)
  );

  arb_sat_counter #(.CntWidth(CntWidth)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc     (stall),
    .clr     (perf_clr_i),
    .count_o (perf_stall_o)
  );
`else
  logic perf_unused;
  assign perf_unused   = ^{perf_clr_i, grant0, grant1, stall};
  assign perf_grant0_o = '0;
  assign perf_grant1_o = '0;
  assign perf_stall_o  = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// compared cycle by cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  import pkg_mem_arb::*;

  localparam int DW = 32;
  localparam int CW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          m0_req_i = 1'b0, m1_req_i = 1'b0;
  logic          m0_write_i = 1'b0, m1_write_i = 1'b0;
  logic [DW-1:0] m0_addr_i = '0, m1_addr_i = '0;
  logic [DW-1:0] m0_wdata_i = '0, m1_wdata_i = '0;
  logic          m0_ready_o, m1_ready_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic          mem_req_o, mem_write_o;
  logic [DW-1:0] mem_addr_o, mem_wdata_o;
  logic          mem_ready_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          perf_clr_i = 1'b0;
  logic [CW-1:0] perf_grant0_o, perf_grant1_o, perf_stall_o;
  arb_state_e    state_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  mem_port_arbiter #(.DWidth(DW), .CntWidth(CW)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .m0_req_i      (m0_req_i),
    .m1_req_i      (m1_req_i),
    .m0_write_i    (m0_write_i),
    .m1_write_i    (m1_write_i),
    .m0_addr_i     (m0_addr_i),
    .m1_addr_i     (m1_addr_i),
    .m0_wdata_i    (m0_wdata_i),
    .m1_wdata_i    (m1_wdata_i),
    .m0_ready_o    (m0_ready_o),
    .m1_ready_o    (m1_ready_o),
    .m0_rdata_o    (m0_rdata_o),
    .m1_rdata_o    (m1_rdata_o),
    .mem_req_o     (mem_req_o),
    .mem_write_o   (mem_write_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_ready_i   (mem_ready_i),
    .mem_rdata_i   (mem_rdata_i),
    .perf_clr_i    (perf_clr_i),
    .perf_grant0_o (perf_grant0_o),
    .perf_grant1_o (perf_grant1_o),
    .perf_stall_o  (perf_stall_o),
    .state_o       (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_ni      = 1'b0;
    m0_req_i    = 1'b0;
    m1_req_i    = 1'b0;
    mem_ready_i = 1'b0;
    perf_clr_i  = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b1;
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_mem_req"}, 64'(mem_req_o), 64'd0);
    check_eq({tag, "_state"}, 64'(state_o), 64'(IDLE));
    check_eq({tag, "_rdy0"}, 64'(m0_ready_o), 64'd0);
    check_eq({tag, "_rdy1"}, 64'(m1_ready_o), 64'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_m(input int m, input logic req, input logic wr,
                         input logic [DW-1:0] addr, input logic [DW-1:0] wdata);
    if (m == 0) begin
      m0_req_i = req; m0_write_i = wr; m0_addr_i = addr; m0_wdata_i = wdata;
    end else begin
      m1_req_i = req; m1_write_i = wr; m1_addr_i = addr; m1_wdata_i = wdata;
    end
  endtask

  // One complete solo transaction for master m with lat wait cycles.
  task automatic serve(input int m, input int lat);
    drive_m(m, 1'b1, 1'b0, DW'($urandom), DW'($urandom));
    tick();
    repeat (lat) tick();
    mem_ready_i = 1'b1;
    mem_rdata_i = DW'($urandom);
    #1;
    check_eq("serve_rdy", 64'(m == 0 ? m0_ready_o : m1_ready_o), 64'd1);
    drive_m(m, 1'b0, 1'b0, '0, '0);
    tick();
    mem_ready_i = 1'b0;
  endtask

  // ---------------- reference model state (random phase) ----------------
  logic          pend [2];
  logic          f_wr [2];
  logic [DW-1:0] f_addr [2];
  logic [DW-1:0] f_wdata [2];
  logic          ref_busy;
  int            ref_owner, ref_last, lat_left;
  int            ref_g0, ref_g1, ref_stall;
  logic          exp_q[$];

  initial begin
    // ---- reset values ----
    apply_reset();
    check_idle_outputs("rst");
    check_eq("rst_addr", 64'(mem_addr_o), 64'd0);
    check_eq("rst_wdata", 64'(mem_wdata_o), 64'd0);
    check_eq("rst_write", 64'(mem_write_o), 64'd0);
    check_eq("rst_rdata0", 64'(m0_rdata_o), 64'd0);
    check_eq("rst_g0", 64'(perf_grant0_o), 64'd0);
    check_eq("rst_stall", 64'(perf_stall_o), 64'd0);

    // ---- single M0 read, memory answers on the third BUSY cycle ----
    drive_m(0, 1'b1, 1'b0, 32'h0000_4000, 32'h0);
    tick();
    check_eq("rd_mem_req", 64'(mem_req_o), 64'd1);
    check_eq("rd_addr", 64'(mem_addr_o), 64'h4000);
    check_eq("rd_write", 64'(mem_write_o), 64'd0);
    check_eq("rd_state", 64'(state_o), 64'(BUSY0));
    for (int i = 0; i < 2; i++) begin
      check_eq("rd_wait_rdy0", 64'(m0_ready_o), 64'd0);
      tick();
    end
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    check_eq("rd_rdy0", 64'(m0_ready_o), 64'd1);
    check_eq("rd_rdata0", 64'(m0_rdata_o), 64'hDEAD_BEEF);
    check_eq("rd_rdy1", 64'(m1_ready_o), 64'd0);
    check_eq("rd_rdata1", 64'(m1_rdata_o), 64'd0);
    m0_req_i = 1'b0;
    tick();
    mem_ready_i = 1'b0;
    check_idle_outputs("rd_done");

    // ---- M1 write, inputs scrambled while in service ----
    drive_m(1, 1'b1, 1'b1, 32'h0000_4010, 32'h1234_5678);
    tick();
    check_eq("wr_state", 64'(state_o), 64'(BUSY1));
    check_eq("wr_write", 64'(mem_write_o), 64'd1);
    check_eq("wr_wdata", 64'(mem_wdata_o), 64'h1234_5678);
    drive_m(1, 1'b1, 1'b0, 32'hFFFF_0000, 32'hCAFE_F00D);
    tick();
    check_eq("wr_hold_write", 64'(mem_write_o), 64'd1);
    check_eq("wr_hold_wdata", 64'(mem_wdata_o), 64'h1234_5678);
    check_eq("wr_hold_addr", 64'(mem_addr_o), 64'h4010);
    check_eq("wr_wait_rdy1", 64'(m1_ready_o), 64'd0);
    mem_ready_i = 1'b1;
    #1;
    check_eq("wr_rdy1", 64'(m1_ready_o), 64'd1);
    check_eq("wr_rdy0", 64'(m0_ready_o), 64'd0);
    m1_req_i = 1'b0;
    tick();
    mem_ready_i = 1'b0;

    // ---- tie straight after reset: M0 first, then M1 after one IDLE cycle ----
    apply_reset();
    drive_m(0, 1'b1, 1'b0, 32'h100, 32'h0);
    drive_m(1, 1'b1, 1'b0, 32'h200, 32'h0);
    tick();
    check_eq("tie_first", 64'(state_o), 64'(BUSY0));
    mem_ready_i = 1'b1;
    #1;
    check_eq("tie_rdy0", 64'(m0_ready_o), 64'd1);
    m0_req_i = 1'b0;
    tick();
    mem_ready_i = 1'b0;
    check_eq("tie_gap", 64'(state_o), 64'(IDLE));
    tick();
    check_eq("tie_second", 64'(state_o), 64'(BUSY1));
    check_eq("tie_addr", 64'(mem_addr_o), 64'h200);
    mem_ready_i = 1'b1;
    #1;
    check_eq("tie_rdy1", 64'(m1_ready_o), 64'd1);
    m1_req_i = 1'b0;
    tick();
    mem_ready_i = 1'b0;

    // ---- continuous contention: strict alternation over 6 transactions ----
    apply_reset();
    drive_m(0, 1'b1, 1'b0, 32'h300, 32'h0);
    drive_m(1, 1'b1, 1'b1, 32'h400, 32'h55);
    for (int t = 0; t < 6; t++) begin
      tick();
      check_eq("alt_grant", 64'(state_o), 64'((t % 2 == 0) ? BUSY0 : BUSY1));
      repeat ($urandom_range(0, 2)) tick();
      mem_ready_i = 1'b1;
      #1;
      check_eq("alt_rdy", 64'((t % 2 == 0) ? m0_ready_o : m1_ready_o), 64'd1);
      tick();
      mem_ready_i = 1'b0;
      check_eq("alt_idle", 64'(state_o), 64'(IDLE));
    end
    m0_req_i = 1'b0;
    m1_req_i = 1'b0;
`ifdef MEM_ARB_PERF_EN
    check_eq("alt_g0", 64'(perf_grant0_o), 64'd3);
    check_eq("alt_g1", 64'(perf_grant1_o), 64'd3);
    check_eq("alt_stall_nz", 64'(perf_stall_o != '0), 64'd1);
`endif

    // ---- reset mid BUSY0, late mem_ready ignored, next tie to M0 ----
    apply_reset();
    serve(1, 0);
    drive_m(0, 1'b1, 1'b0, 32'h500, 32'h0);
    tick();
    check_eq("rmid_busy", 64'(state_o), 64'(BUSY0));
    #1;
    rst_ni   = 1'b0;
    m0_req_i = 1'b0;
    #1;
    check_eq("rmid_req", 64'(mem_req_o), 64'd0);
    check_eq("rmid_state", 64'(state_o), 64'(IDLE));
    tick();
    mem_ready_i = 1'b1;
    #1;
    check_eq("rmid_rdy0", 64'(m0_ready_o), 64'd0);
    rst_ni = 1'b1;
    tick();
    check_eq("rmid_late_rdy0", 64'(m0_ready_o), 64'd0);
    check_eq("rmid_late_state", 64'(state_o), 64'(IDLE));
    mem_ready_i = 1'b0;
    drive_m(0, 1'b1, 1'b0, 32'h600, 32'h0);
    drive_m(1, 1'b1, 1'b0, 32'h700, 32'h0);
    tick();
    check_eq("rmid_tie", 64'(state_o), 64'(BUSY0));
    mem_ready_i = 1'b1;
    m0_req_i = 1'b0;
    m1_req_i = 1'b0;
    tick();
    mem_ready_i = 1'b0;

`ifdef MEM_ARB_PERF_EN
    // ---- saturation and clear-beats-increment ----
    apply_reset();
    force dut.u_grant0_cnt.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_grant0_cnt.count_q;
    serve(0, 0);
    serve(0, 1);
    check_eq("sat_g0", 64'(perf_grant0_o), 64'hFFFF_FFFF);
    drive_m(0, 1'b1, 1'b0, 32'h800, 32'h0);
    perf_clr_i = 1'b1;
    tick();
    perf_clr_i = 1'b0;
    check_eq("clr_state", 64'(state_o), 64'(BUSY0));
    check_eq("clr_g0", 64'(perf_grant0_o), 64'd0);
    mem_ready_i = 1'b1;
    m0_req_i = 1'b0;
    tick();
    mem_ready_i = 1'b0;
`endif

    // ---- randomized traffic against the transaction-level model ----
    apply_reset();
    for (int m = 0; m < 2; m++) pend[m] = 1'b0;
    ref_busy = 1'b0; ref_owner = 0; ref_last = 1; lat_left = 0;
    ref_g0 = 0; ref_g1 = 0; ref_stall = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && ($urandom_range(0, 99) < 60)) begin
          pend[m]    = 1'b1;
          f_wr[m]    = 1'($urandom);
          f_addr[m]  = DW'($urandom);
          f_wdata[m] = DW'($urandom);
        end
        if (pend[m]) drive_m(m, 1'b1, f_wr[m], f_addr[m], f_wdata[m]);
        else drive_m(m, 1'b0, 1'($urandom), DW'($urandom), DW'($urandom));
      end
      mem_rdata_i = DW'($urandom);
      if (ref_busy) begin
        mem_ready_i = (lat_left == 0);
        if (lat_left > 0) lat_left--;
      end else begin
        mem_ready_i = 1'($urandom);
      end
      #1;
      // Expected outputs for this cycle.
      exp_q.delete();
      exp_q.push_back(ref_busy && ref_owner == 0 && mem_ready_i);
      exp_q.push_back(ref_busy && ref_owner == 1 && mem_ready_i);
      check_eq("rnd_mem_req", 64'(mem_req_o), 64'(ref_busy));
      check_eq("rnd_state", 64'(state_o),
               64'(!ref_busy ? IDLE : (ref_owner == 0 ? BUSY0 : BUSY1)));
      check_eq("rnd_rdy0", 64'(m0_ready_o), 64'(exp_q[0]));
      check_eq("rnd_rdy1", 64'(m1_ready_o), 64'(exp_q[1]));
      check_eq("rnd_rdata0", 64'(m0_rdata_o), 64'(exp_q[0] ? mem_rdata_i : '0));
      check_eq("rnd_rdata1", 64'(m1_rdata_o), 64'(exp_q[1] ? mem_rdata_i : '0));
      if (ref_busy) begin
        check_eq("rnd_addr", 64'(mem_addr_o), 64'(f_addr[ref_owner]));
        check_eq("rnd_write", 64'(mem_write_o), 64'(f_wr[ref_owner]));
        check_eq("rnd_wdata", 64'(mem_wdata_o), 64'(f_wdata[ref_owner]));
      end
`ifdef MEM_ARB_PERF_EN
      check_eq("rnd_g0", 64'(perf_grant0_o), 64'(ref_g0));
      check_eq("rnd_g1", 64'(perf_grant1_o), 64'(ref_g1));
      check_eq("rnd_stall", 64'(perf_stall_o), 64'(ref_stall));
`endif
      // Advance the model by one clock.
      if ((pend[0] && !(ref_busy && ref_owner == 0)) ||
          (pend[1] && !(ref_busy && ref_owner == 1))) ref_stall++;
      if (ref_busy) begin
        if (mem_ready_i) begin
          pend[ref_owner] = 1'b0;
          ref_busy = 1'b0;
        end
      end else if (pend[0] || pend[1]) begin
        ref_owner = (pend[0] && pend[1]) ? (1 - ref_last) : (pend[0] ? 0 : 1);
        ref_last  = ref_owner;
        ref_busy  = 1'b1;
        lat_left  = $urandom_range(0, 3);
        if (ref_owner == 0) ref_g0++;
        else ref_g1++;
      end
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
